// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, FSM state type and pipeline beat record for the line responder.
package mem_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_OFF_W = $clog2(WORDS_PER_LINE);
   localparam int WORD_ADDR_W = ADDR_W - 1;
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} mem_state_t;
   typedef struct packed {
      logic valid;
      logic last;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_beat_t;
endpackage

// File: rtl/mem_delay_pipe.sv
// mem_delay_pipe: fixed-latency shift register of response beats, cleared on rst.
module mem_delay_pipe
   import mem_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  mem_beat_t beat_in,
   output mem_beat_t beat_out
);
   mem_beat_t stage [LATENCY];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= beat_in;
         for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
   end
   assign beat_out = stage[LATENCY-1];
endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: word array serving single reads/writes and critical-word-first
// wrapping line fills through a fixed-latency response pipe.
module mem_line_responder
   import mem_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_burst,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic [ADDR_W-1:0] resp_addr,
   output logic              resp_last
);
   localparam logic [LINE_OFF_W-1:0] LAST_BEAT = LINE_OFF_W'(WORDS_PER_LINE - 1);
   mem_state_t state;
   logic [LINE_OFF_W-1:0] beat_cnt, start_off;
   logic [WORD_ADDR_W-LINE_OFF_W-1:0] line_tag;
   logic [DATA_W-1:0] mem [2**WORD_ADDR_W];
   logic [WORD_ADDR_W-1:0] req_word, issue_word;
   logic accept, issue, issue_last, unused_bit;
   mem_beat_t beat_in, beat_out;
   assign req_ready = state == IDLE;
   assign req_word = req_addr[ADDR_W-1:1];
   assign accept = req_valid && req_ready;
   assign unused_bit = req_addr[0];
   // Offset sum is LINE_OFF_W wide, so the wrap stays inside the line.
   always_comb begin
      issue = state == BURST || (accept && !req_write);
      issue_word = state == BURST ? {line_tag, start_off + beat_cnt} : req_word;
      issue_last = issue && (state == BURST ? beat_cnt == LAST_BEAT : !req_burst);
      beat_in = '{valid: issue, last: issue_last, addr: {issue_word, 1'b0}, data: mem[issue_word]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         beat_cnt <= '0;
         start_off <= '0;
         line_tag <= '0;
      end else if (state == IDLE) begin
         if (accept && !req_write && req_burst) begin
            state <= BURST;
            beat_cnt <= LINE_OFF_W'(1);
            start_off <= req_word[LINE_OFF_W-1:0];
            line_tag <= req_word[WORD_ADDR_W-1:LINE_OFF_W];
         end
      end else begin
         beat_cnt <= beat_cnt + LINE_OFF_W'(1);
         state <= beat_cnt == LAST_BEAT ? IDLE : BURST;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && accept && req_write) mem[req_word] <= req_wdata;
   end
   mem_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
      .clk(clk),
      .rst(rst),
      .beat_in(beat_in),
      .beat_out(beat_out)
   );
   assign resp_valid = beat_out.valid;
   assign resp_last = beat_out.last;
   assign resp_addr = beat_out.addr;
   assign resp_data = beat_out.data;
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_mem_line_responder;
   localparam int L = 4;
   typedef struct {
      logic [15:0] d;
      logic [15:0] a;
      logic        l;
      int          c;
   } exp_t;
   logic clk = 0, rst = 1;
   logic req_valid = 0, req_write = 0, req_burst = 0;
   logic req_ready, resp_valid, resp_last;
   logic [15:0] req_addr = 0, req_wdata = 0, resp_data, resp_addr;
   int cyc = 0, checks = 0, errors = 0;
   exp_t sb[$];
   mem_line_responder #(.LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_burst(req_burst), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_addr(resp_addr), .resp_last(resp_last)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         checks++;
         if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: resp_valid=%b required 0 (cycle %0d)", resp_valid, cyc);
         end
      end else begin
         while (sb.size() > 0 && sb[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_beat: no response for addr %h by cycle %0d (got none, required at %0d)", sb[0].a, cyc, sb[0].c);
            void'(sb.pop_front());
         end
         if (resp_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got data %h addr %h at cycle %0d, required no response", resp_data, resp_addr, cyc);
            end else begin
               e = sb.pop_front();
               if (e.c != cyc || resp_data !== e.d || resp_addr !== e.a || resp_last !== e.l) begin
                  errors++;
                  $display("FAIL beat: got cyc %0d data %h addr %h last %b, required cyc %0d data %h addr %h last %b",
                           cyc, resp_data, resp_addr, resp_last, e.c, e.d, e.a, e.l);
               end
            end
         end
      end
   end
   task automatic push(input logic [15:0] a, input logic [15:0] d, input logic l, input int c);
      exp_t e;
      e.a = a; e.d = d; e.l = l; e.c = c;
      sb.push_back(e);
   endtask
   task automatic req(input logic w, input logic b, input logic [15:0] a, input logic [15:0] wd, output int e);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: req_ready=%b required 1 within 20 cycles", req_ready);
      end
      req_write = w; req_burst = b; req_addr = a; req_wdata = wd; req_valid = 1;
      e = cyc + 1;
      @(posedge clk);
      #1;
   endtask
   task automatic check_ready(input logic exp, input string name);
      checks++;
      if (req_ready !== exp) begin
         errors++;
         $display("FAIL %s: req_ready=%b required %b (cycle %0d)", name, req_ready, exp, cyc);
      end
   endtask
   initial begin
      int e, e2, n;
      logic [15:0] bd [8] = '{16'h00A5, 16'h00A6, 16'h00A7, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
      logic [15:0] ba [8] = '{16'h001A, 16'h001C, 16'h001E, 16'h0010, 16'h0012, 16'h0014, 16'h0016, 16'h0018};
      logic [15:0] rd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      logic [15:0] ra [4] = '{16'h0040, 16'h0042, 16'h0044, 16'h0046};
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_ready(1'b1, "reset_ready");
      end
      req(1, 0, 16'h0002, 16'h0005, e);
      req(0, 0, 16'h0002, 16'h0000, e);
      push(16'h0002, 16'h0005, 1'b1, e + L - 1);
      req_valid = 0;
      for (int i = 0; i < 8; i++) req(1, 0, 16'h0010 + 16'(2 * i), 16'h00A0 + 16'(i), e);
      for (int i = 0; i < 4; i++) req(1, 0, ra[i], rd[i], e);
      req_valid = 0;
      req(0, 1, 16'h001A, 16'h0000, e);
      req_valid = 0;
      for (int k = 0; k < 8; k++) push(ba[k], bd[k], k == 7, e + L - 1 + k);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check_ready(1'b0, "burst_busy");
      end
      @(negedge clk);
      check_ready(1'b1, "burst_done");
      for (int i = 0; i < 4; i++) begin
         req(0, 0, ra[i], 16'h0000, e);
         push(ra[i], rd[i], 1'b1, e + L - 1);
      end
      req_valid = 0;
      req(0, 1, 16'h0010, 16'h0000, e);
      req_valid = 0;
      for (int k = 0; k < 8; k++) push(16'h0010 + 16'(2 * k), 16'h00A0 + 16'(k), k == 7, e + L - 1 + k);
      req(0, 0, 16'h0002, 16'h0000, e2);
      req_valid = 0;
      push(16'h0002, 16'h0005, 1'b1, e2 + L - 1);
      checks++;
      if (e2 != e + 8) begin
         errors++;
         $display("FAIL adjacent_accept: accepted at %0d, required %0d", e2, e + 8);
      end
      n = 0;
      while (sb.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      req(0, 1, 16'h001A, 16'h0000, e);
      req_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      sb.delete();
      @(negedge clk);
      rst = 0;
      check_ready(1'b1, "ready_after_reset");
      repeat (12) @(negedge clk);
      req(0, 0, 16'h0040, 16'h0000, e);
      req_valid = 0;
      push(16'h0040, 16'h1111, 1'b1, e + L - 1);
      n = 0;
      while (sb.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
